// File: rtl/if_stage.sv
// if_stage: RISC-V instruction fetch stage.
// Owns the PC, issues single-outstanding imem requests, fills IF/ID.
module if_stage #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_d, id_pc_d;
    logic [31:0]     id_instr_d;
    logic            id_valid_d;
    logic [31:0]     skid_q, skid_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_tgt;
    logic            unused_brpc;

    assign pc_inc      = pc + PC_W'(4);
    assign br_tgt      = {BrPC[PC_W-1:2], 2'b00};
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // next-state: redirect wins; DROP waits out the squashed response
    always_comb begin
        state_d = state_q;
        if (PcSel) begin
            unique case (state_q)
                FETCH:   state_d = imem_rvalid ? FETCH : DROP;
                HOLD:    state_d = FETCH;
                DROP:    state_d = imem_rvalid ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH:   if (imem_rvalid && Stall) state_d = HOLD;
                HOLD:    if (!Stall) state_d = FETCH;
                DROP:    if (imem_rvalid) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // datapath next values: PC, IF/ID and skid buffer
    always_comb begin
        pc_d       = pc;
        id_pc_d    = id_pc;
        id_instr_d = id_instr;
        id_valid_d = id_valid;
        skid_d     = skid_q;
        if (PcSel) begin
            pc_d       = br_tgt;
            id_instr_d = NOP;
            id_valid_d = 1'b0;
            skid_d     = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_rvalid && !Stall) begin
                        id_pc_d    = pc;
                        id_instr_d = imem_rdata;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end else if (imem_rvalid) begin
                        skid_d = imem_rdata;
                    end else if (!Stall) begin
                        id_instr_d = NOP;
                        id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        id_pc_d    = pc;
                        id_instr_d = skid_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc;
                    end
                end
                DROP: begin
                    if (!Stall) begin
                        id_instr_d = NOP;
                        id_valid_d = 1'b0;
                    end
                end
                default: begin
                    id_instr_d = NOP;
                    id_valid_d = 1'b0;
                end
            endcase
        end
    end

    // PC, IF/ID and skid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            id_pc    <= '0;
            id_instr <= NOP;
            id_valid <= 1'b0;
            skid_q   <= '0;
        end else begin
            pc       <= pc_d;
            id_pc    <= id_pc_d;
            id_instr <= id_instr_d;
            id_valid <= id_valid_d;
            skid_q   <= skid_d;
        end
    end

    // request decode: only FETCH asks memory, never during reset
    always_comb begin
        imem_req  = !reset && (state_q == FETCH);
        imem_addr = pc;
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage
// against a flag-based fetch model and a latency-programmable memory.
module tb_if_stage;
    localparam int          PC_W = 9;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset, PcSel, Stall;
    logic [31:0]     BrPC;
    logic            imem_req, imem_rvalid;
    logic [PC_W-1:0] imem_addr, pc, id_pc;
    logic [31:0]     imem_rdata, id_instr;
    logic            id_valid;

    always #5 clk = ~clk;

    if_stage #(.PC_W(PC_W), .RESET_PC('0), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC),
        .Stall(Stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory: one outstanding request, fixed or random latency
    bit              busy = 0;
    int              cnt = 0;
    logic [PC_W-1:0] maddr = '0;
    int              lat_cfg = 0;
    bit              rand_lat = 0;

    // reference: expected PC, IF/ID, buffered word, stale-response flag
    logic [PC_W-1:0] m_pc = '0;
    logic [PC_W-1:0] m_id_pc = '0;
    logic [31:0]     m_instr = NOP;
    bit              m_valid = 0;
    logic [31:0]     m_buf = '0;
    bit              m_buf_full = 0;
    bit              m_squash = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit sel,
                        input logic [31:0] br, input bit stl);
        bit req_e;
        bit outstanding;
        @(negedge clk);
        reset = rst;
        PcSel = sel;
        BrPC  = br;
        Stall = stl;
        #1;
        req_e = !rst && !m_buf_full && !m_squash;
        check("imem_req", {31'b0, imem_req}, {31'b0, req_e});
        if (req_e) check("imem_addr", {23'b0, imem_addr}, {23'b0, m_pc});
        if (!rst && !busy && imem_req) begin
            busy  = 1;
            maddr = imem_addr;
            cnt   = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
        end else if (busy && imem_req) begin
            check("addr_stable", {23'b0, imem_addr}, {23'b0, maddr});
        end
        imem_rvalid = !rst && busy && (cnt == 0);
        imem_rdata  = imem_rvalid ? ({23'b0, maddr} ^ 32'hA5) : $urandom;
        outstanding = req_e || m_squash;
        if (rst) begin
            m_pc = '0; m_id_pc = '0; m_instr = NOP; m_valid = 0;
            m_buf_full = 0; m_squash = 0;
        end else if (sel) begin
            m_squash   = outstanding && !imem_rvalid;
            m_pc       = PC_W'((br % 512) / 4 * 4);
            m_instr    = NOP;
            m_valid    = 0;
            m_buf_full = 0;
        end else if (m_squash) begin
            if (imem_rvalid) m_squash = 0;
            if (!stl) begin m_instr = NOP; m_valid = 0; end
        end else if (m_buf_full) begin
            if (!stl) begin
                m_id_pc = m_pc; m_instr = m_buf; m_valid = 1;
                m_pc = m_pc + 4; m_buf_full = 0;
            end
        end else if (imem_rvalid && stl) begin
            m_buf = imem_rdata; m_buf_full = 1;
        end else if (imem_rvalid) begin
            m_id_pc = m_pc; m_instr = imem_rdata; m_valid = 1;
            m_pc = m_pc + 4;
        end else if (!stl) begin
            m_instr = NOP; m_valid = 0;
        end
        @(posedge clk);
        #1;
        if (rst || imem_rvalid) busy = 0;
        else if (busy) cnt--;
        check("pc", {23'b0, pc}, {23'b0, m_pc});
        check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check("id_instr", id_instr, m_instr);
        if (m_valid) check("id_pc", {23'b0, id_pc}, {23'b0, m_id_pc});
    endtask

    initial begin
        imem_rvalid = 0;
        imem_rdata  = '0;
        // straight line, zero-wait
        lat_cfg = 0;
        step(1, 0, 0, 0);
        check("rst_instr", id_instr, NOP);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            check("seq_pc", {23'b0, id_pc}, 32'(i * 4));
        end
        // taken branch at pc 0x10
        step(0, 1, 32'h40, 0);
        check("br_bubble", id_instr, NOP);
        step(0, 0, 0, 0);
        check("br_tgt", {23'b0, id_pc}, 32'h40);
        step(0, 1, 32'hFFFF_FE42, 0);
        check("br_mask", {23'b0, pc}, 32'h40);
        // slow memory, redirect one cycle into the wait
        lat_cfg = 3;
        step(0, 0, 0, 0);
        step(0, 1, 32'h80, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("slow_addr", {23'b0, imem_addr}, 32'h80);
        check("slow_req", {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        check("slow_tgt", {23'b0, id_pc}, 32'h80);
        // stall with skid at pc 0x8
        lat_cfg = 0;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("hold_pc", {23'b0, id_pc}, 32'h4);
        step(0, 0, 0, 0);
        check("skid_pc", {23'b0, id_pc}, 32'h8);
        check("skid_word", id_instr, 32'h8 ^ 32'hA5);
        step(0, 0, 0, 0);
        check("after_skid", {23'b0, id_pc}, 32'hC);
        // redirect during stall
        step(0, 0, 0, 1);
        step(0, 1, 32'h100, 1);
        check("rds_bubble", {31'b0, id_valid}, 32'h0);
        check("rds_pc", {23'b0, pc}, 32'h100);
        step(0, 0, 0, 0);
        // wrap-around
        step(0, 1, 32'h1FC, 0);
        step(0, 0, 0, 0);
        check("wrap_pc", {23'b0, pc}, 32'h0);
        check("wrap_id", {23'b0, id_pc}, 32'h1FC);
        // reset mid-wait
        lat_cfg = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_pc", {23'b0, pc}, 32'h0);
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        // random traffic
        rand_lat = 1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                 $urandom, $urandom_range(0, 3) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, issues single-outstanding requests to the instruction memory, and fills the IF/ID pipeline register. It consumes the `PcSel`/`BrPC` redirect produced by the branch unit in EX and the `Stall` signal from the hazard unit. It discards wrong-path fetches so that ID only ever sees correct-path instructions or NOP bubbles.

## Interface
- `PC_W`, 9, PC width in bits; byte address; the PC wraps modulo 2^PC_W.
- `RESET_PC`, 0, PC value loaded on reset; word aligned.
- `NOP`, 32'h00000013, bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PcSel`  in  1  redirect request from the branch unit; valid every cycle.
- `BrPC`  in  32  redirect target; only bits [PC_W-1:2] are used.
- `Stall`  in  1  hold IF/ID and PC (hazard unit).
- `imem_req`  out  1  fetch request active.
- `imem_addr`  out  PC_W  fetch address (= `pc`).
- `imem_rvalid`  in  1  read data valid for the outstanding request.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  PC_W  current fetch PC.
- `id_pc`  out  PC_W  IF/ID: PC of `id_instr`.
- `id_instr`  out  32  IF/ID: instruction.
- `id_valid`  out  1  IF/ID: 1 = real instruction, 0 = bubble.

## Operation
- Reset: `pc`=RESET_PC, state=FETCH, `id_valid`=0, `id_instr`=NOP, `id_pc`=0, skid buffer cleared. `imem_req`=0 while `reset` is high.
- The state machine has three states: FETCH, HOLD and DROP.
- **FETCH:** `imem_req`=1, `imem_addr`=`pc`. The address is held stable until `imem_rvalid`. `imem_rvalid` may rise in the same cycle as the request (zero-wait memory) or any later cycle.
  - `rvalid` and not `Stall`: IF/ID <= {`pc`, `rdata`, 1}; `pc` <= `pc`+4; stay in FETCH.
  - `rvalid` and `Stall`: the word goes into the skid buffer; go to HOLD; IF/ID and `pc` are unchanged.
  - No `rvalid` and not `Stall`: IF/ID <= bubble (`id_valid`=0, `id_instr`=NOP).
  - No `rvalid` and `Stall`: IF/ID is held.
- **HOLD:** `imem_req`=0. While `Stall` is high, everything is held. When `Stall` falls: IF/ID <= {`pc`, buffer, 1}; `pc` <= `pc`+4; go to FETCH.
- **Redirect (`PcSel`=1) has priority over `Stall` and over every state:**
  - `pc` <= {`BrPC`[PC_W-1:2], 2'b00}. Upper bits are ignored; the low two bits are forced to 0.
  - IF/ID <= bubble, even if `Stall` is high.
  - From FETCH with `rvalid` in the same cycle: the data is discarded; next state is FETCH.
  - From FETCH without `rvalid`: go to DROP.
  - From HOLD: the buffer is discarded; next state is FETCH.
  - From DROP: the target is updated; stay in DROP.
- **DROP:** `imem_req`=0. Wait for the `rvalid` of the squashed request, discard it, then go to FETCH at `pc`. IF/ID shows a bubble unless `Stall` is high, in which case it holds. A `PcSel` in the same cycle as the DROP `rvalid` updates `pc` and goes to FETCH.
- Arithmetic: `pc`+4 is PC_W bits wide and wraps, e.g. 0x1FC -> 0x000 for PC_W=9.
- An `imem_rvalid` arriving outside FETCH/DROP is ignored.

## Timing
- With a zero-wait memory, throughput is 1 instruction/cycle. An instruction appears in IF/ID on the edge at which its `rvalid` is seen.
- Redirect penalty with zero-wait memory: the `PcSel` edge produces one bubble in IF/ID. The target is requested in the next cycle and appears in IF/ID one edge later.
- Redirect during an N-cycle outstanding fetch: the DROP state lasts until the old `rvalid`, plus one cycle to re-request the target.
- All outputs are registered except `imem_req` and `imem_addr`. `imem_req` is decoded from the state and `reset`; `imem_addr` equals `pc`.
- Reset in the middle of an outstanding request: the state returns to FETCH at RESET_PC. The memory must drop its pending response on `reset`.

## Test plan
- **Straight-line, zero-wait memory:** reset, then `rvalid`=1 every cycle with `rdata`=addr^0xA5 → `id_pc` sequence 0,4,8,C on consecutive cycles, `id_valid`=1.
- **Taken branch:** `PcSel`=1 and `BrPC`=0x40 while `pc`=0x10 → exactly one bubble (`id_instr`=0x00000013), then `id_pc`=0x40. A `BrPC` of 0xFFFF_FE42 gives `pc`=0x040.
- **Slow memory with redirect:** `rvalid` 3 cycles after the request; `PcSel` (`BrPC`=0x80) 1 cycle into the wait → `imem_req`=0 until the stale `rvalid`, which is discarded. Next `imem_addr`=0x80; the stale data never reaches `id_instr`.
- **Stall with skid:** `Stall`=1 for 3 cycles coinciding with `rvalid` at `pc`=0x8 → IF/ID frozen and `imem_req`=0 in HOLD. On release, `id_pc`=0x8 with the buffered word, then 0xC follows.
- **Redirect during stall:** `Stall`=1 and `PcSel`=1 together → bubble in IF/ID, `pc`=target, buffer dropped.
- **Wrap-around and reset:** `pc`=0x1FC plus fetch gives `pc`=0x000. Asserting `reset` mid-wait → `pc`=RESET_PC, `id_valid`=0 on the next edge.
